capture_result_fifo: RTL and testbench
======================================

# capture_result_fifo

Downstream stage of the capture counter. Latches the 32-bit capture count on each rising edge of `capture_complete` and queues it in a small show-ahead FIFO. Software or a bus adapter drains the FIFO through a valid/ready read port. A sticky overflow flag records captures dropped because the queue was full.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of two, at least 2.
- `AW`, 2: log2(`DEPTH`); pointer width is `AW`+1.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `counter`, input, 32: capture count from the capture counter; stable while `capture_complete` is high.
- `capture_complete`, input, 1: level from the capture counter; high for the whole WAIT period.
- `rd_data`, output, 32: head entry; valid only while `rd_valid`=1.
- `rd_valid`, output, 1: FIFO not empty.
- `rd_ready`, input, 1: consumer accepts the head entry when `rd_valid`&&`rd_ready`.
- `level`, output, `AW`+1: entry count, 0..`DEPTH`.
- `full`, output, 1: `level`==`DEPTH`.
- `overflow`, output, 1: sticky; a capture was dropped.
- `clear_overflow`, input, 1: synchronous clear of `overflow` and `drop_count`.
- `drop_count`, output, 8: dropped-capture count (see Configuration).

## Operation
- Edge detect:
  - `cc_d` registers `capture_complete`.
  - `push` = `capture_complete` && !`cc_d`, giving exactly one push per capture regardless of WAIT length.
- Pop:
  - `pop` = `rd_valid` && `rd_ready`.
  - `rd_ready` while empty has no effect.
- Storage:
  - Register array `mem[DEPTH]`; `wr_ptr` and `rd_ptr` are `AW`+1 bits wide and wrap modulo 2·`DEPTH`.
  - `level` = `wr_ptr` − `rd_ptr`.
  - `rd_data` = `mem[rd_ptr[AW-1:0]]`, a combinational show-ahead read.
- Push when not full: write `counter` to `mem[wr_ptr]`, then `wr_ptr`+1.
- Push when full:
  - With a simultaneous pop, both occur, nothing is lost, and `level` stays `DEPTH`.
  - Without a pop, the sample is discarded, pointers are unchanged, and `overflow` is set to 1.
- Push and pop on the same cycle while not full: both occur and `level` is unchanged.
- `clear_overflow`:
  - Clears `overflow` to 0.
  - If a drop occurs in the same cycle, the drop wins and `overflow` is 1 afterwards.
- Reset (asynchronous, at any time, including mid-transfer):
  - `wr_ptr`=`rd_ptr`=0, `overflow`=0, `drop_count`=0.
  - `cc_d`=1, so a `capture_complete` still high at reset release is not captured.
  - `mem` contents are not reset.
- Reset values of outputs: `rd_valid`=0, `level`=0, `full`=0, `overflow`=0, `drop_count`=0. `rd_data` is undefined while `rd_valid`=0.

## Timing
- Capture latency:
  - `capture_complete` is first sampled high at edge N with `cc_d`=0, and the write happens at edge N.
  - `rd_valid`, `level` and `rd_data` reflect the new entry after edge N, i.e. one cycle after `capture_complete` rises.
- Pop takes effect at the edge where `pop`=1. The next entry, or `rd_valid`=0, is presented after that edge.
- `full`, `rd_valid` and `level` are derived from registered pointers and contain no combinational path from `rd_ready`.
- Back-to-back captures need `capture_complete` to fall and rise again. The minimum push spacing is 2 cycles.

## Configuration
- `CAPTURE_FIFO_DROP_CNT_EN` defined:
  - An 8-bit counter increments on each dropped push.
  - It saturates at 255 and is cleared by `clear_overflow`.
  - A drop on the same cycle as `clear_overflow` leaves `drop_count`=1.
- Not defined:
  - No counter logic is built and `drop_count` is tied to 0.
  - `overflow` behaviour is unchanged.

## Test plan
- Reset, then `counter`=0x0000_1234 and `capture_complete` 0→1 held 5 cycles → exactly one entry. `rd_valid`=1 one cycle after the rise, `rd_data`=0x1234, `level`=1.
- Four captures (0x10, 0x20, 0x30, 0x40) with `rd_ready`=0, then drain with `rd_ready`=1 → `full`=1 after the 4th. Reads return 0x10, 0x20, 0x30, 0x40 on consecutive cycles, then `rd_valid`=0.
- Full FIFO, fifth capture 0x50 with `rd_ready`=0 → `overflow`=1, `level`=4, 0x50 never read. With the macro, `drop_count`=1.
- Full FIFO, capture 0x60 coincident with pop → no overflow, `level`=4, last read returns 0x60.
- `capture_complete` held high across `reset` assertion and release → no entry created. `clear_overflow` coincident with a drop → `overflow` remains 1.
- `reset` asserted mid-drain with 3 entries → asynchronously `rd_valid`=0 and `level`=0. The next capture 0x99 reads back as 0x99.

Source files
------------

// File: rtl/capture_result_fifo.sv
// Show-ahead FIFO of capture counts, one entry per capture_complete rise.
// Optional macro CAPTURE_FIFO_DROP_CNT_EN adds a saturating drop counter.
module capture_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   counter,
  input  logic          capture_complete,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
  input  logic          clear_overflow,
  output logic [7:0]    drop_count
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        cc_d;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic        drop;

  assign push     = capture_complete && !cc_d;
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == DEPTH_L);
  assign rd_valid = (wr_ptr != rd_ptr);
  assign pop      = rd_valid && rd_ready;
  // A pop frees the head slot this edge, so a push into a full queue still fits
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= counter;
  end

  // cc_d resets high so a capture still pending at release is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_d   <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      cc_d <= capture_complete;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clear_overflow)
      overflow <= 1'b0;
  end

`ifdef CAPTURE_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (drop) begin
      if (clear_overflow)
        drop_count <= 8'd1;
      else if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end else if (clear_overflow)
      drop_count <= '0;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_capture_result_fifo.sv
// Bench for capture_result_fifo: vector table plus read-side scoreboard.
// Expected drop counts follow CAPTURE_FIFO_DROP_CNT_EN.
module tb_capture_result_fifo;

  logic        clk;
  logic        reset;
  logic [31:0] counter;
  logic        capture_complete;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  level;
  logic        full;
  logic        overflow;
  logic        clear_overflow;
  logic [7:0]  drop_count;

  int compared;
  int mismatched;
  logic [31:0] sb [$];

  capture_result_fifo #(.DEPTH(4), .AW(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .counter          (counter),
    .capture_complete (capture_complete),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .level            (level),
    .full             (full),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic        acc;
    logic [2:0]  lvl;
    logic        full;
    logic        ovf;
    logic [7:0]  drop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xdrop(input logic [7:0] d);
`ifdef CAPTURE_FIFO_DROP_CNT_EN
    return d;
`else
    return (d == 8'd0) ? 8'd0 : 8'd0;
`endif
  endfunction

  // Read side: every accepted pop must match the oldest queued capture
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
      end else begin
        chk("pop_data", rd_data, sb.pop_front());
      end
    end
  end

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) step();
    rd_ready = 1'b0;
  endtask

  vec_t vt [7];

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    counter = '0;
    capture_complete = 1'b0;
    rd_ready = 1'b0;
    clear_overflow = 1'b0;

    vt[0] = '{32'h10, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0};
    vt[1] = '{32'h20, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'd0};
    vt[2] = '{32'h30, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 8'd0};
    vt[3] = '{32'h40, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0};
    vt[4] = '{32'h50, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
    vt[5] = '{32'h60, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0};
    vt[6] = '{32'h70, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};

    @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    step();
    reset = 1'b0;
    step();

    // Long WAIT yields a single entry
    counter = 32'h0000_1234;
    capture_complete = 1'b1;
    sb.push_back(32'h0000_1234);
    step();
    @(negedge clk);
    chk("cap_valid", rd_valid, 1);
    chk("cap_data", rd_data, 32'h1234);
    chk("cap_level", level, 1);
    repeat (4) step();
    capture_complete = 1'b0;
    step();
    @(negedge clk);
    chk("hold_level", level, 1);
    drain(1);
    @(negedge clk);
    chk("t1_empty", rd_valid, 0);

    for (int i = 0; i < 7; i++) begin
      counter = vt[i].data;
      capture_complete = 1'b1;
      rd_ready = vt[i].rdy;
      clear_overflow = vt[i].clr;
      if (vt[i].acc) sb.push_back(vt[i].data);
      step();
      capture_complete = 1'b0;
      rd_ready = 1'b0;
      clear_overflow = 1'b0;
      step();
      @(negedge clk);
      chk($sformatf("v%0d_level", i), level, vt[i].lvl);
      chk($sformatf("v%0d_full", i), full, vt[i].full);
      chk($sformatf("v%0d_ovf", i), overflow, vt[i].ovf);
      chk($sformatf("v%0d_drop", i), drop_count, xdrop(vt[i].drop));
    end
    drain(4);
    @(negedge clk);
    chk("drain_valid", rd_valid, 0);
    chk("drain_level", level, 0);

    // Capture held high across reset must not enqueue
    counter = 32'hDEAD_BEEF;
    capture_complete = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    capture_complete = 1'b0;
    step();
    @(negedge clk);
    chk("rsthold_level", level, 0);
    chk("rsthold_ovf", overflow, 0);
    chk("rsthold_drop", drop_count, 0);

    for (int i = 0; i < 3; i++) begin
      counter = 32'hA1 + i;
      capture_complete = 1'b1;
      sb.push_back(32'hA1 + i);
      step();
      capture_complete = 1'b0;
      step();
    end
    rd_ready = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("async_valid", rd_valid, 0);
    chk("async_level", level, 0);
    sb.delete();
    rd_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    counter = 32'h99;
    capture_complete = 1'b1;
    sb.push_back(32'h99);
    step();
    capture_complete = 1'b0;
    @(negedge clk);
    chk("post_rst_data", rd_data, 32'h99);
    step();
    drain(1);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("final_valid", rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
